unified_mem_ctrl: RTL and testbench

Memory-side responder for the MIPS CPU's instruction and data ports: services instruction fetches and data loads/stores from a single-port synchronous word RAM. Sits between the datapath's `inst_*`/`mem_*` request signals and the backing store, arbitrating simultaneous requests, inserting configurable wait states, and driving a stall to the pipeline.

---
 rtl/unified_mem_ctrl_pkg.sv | 19 +
 rtl/unified_mem_ctrl_if.sv | 28 ++
 rtl/unified_mem_ctrl_mem_sp_ram.sv | 26 ++
 rtl/unified_mem_ctrl.sv | 120 ++++++++++++
 tb/tb_unified_mem_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_ctrl_pkg.sv
// Shared types for the unified instruction/data memory controller.
// Holds FSM state encodings, port identifiers and datapath widths.
package unified_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_t;

    localparam int WORD_W     = 32;
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/unified_mem_ctrl_if.sv
// CPU-side request/response bundle: instruction port, data port and stall.
// master = CPU pipeline, slave = memory controller.
interface unified_mem_ctrl_if;
    import unified_mem_ctrl_pkg::*;

    logic              inst_ren;
    logic [WORD_W-1:0] inst_addr;
    logic [WORD_W-1:0] inst_data;
    logic              inst_ack;
    logic              mem_ren;
    logic              mem_wen;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_dout;
    logic [WORD_W-1:0] mem_din;
    logic              mem_ack;
    logic              mem_stall;

    modport master (
        output inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout,
        input  inst_data, inst_ack, mem_din, mem_ack, mem_stall
    );

    modport slave (
        input  inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout,
        output inst_data, inst_ack, mem_din, mem_ack, mem_stall
    );

endinterface

// File: rtl/unified_mem_ctrl_mem_sp_ram.sv
// Single-port synchronous word RAM, read-first, one-cycle registered read.
// Contents are not reset and start without any preloaded image.
module mem_sp_ram
    import unified_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_W-1:0]     wdat,
    output logic [WORD_W-1:0]     rdat
);

    logic [WORD_W-1:0] mem [2**ADDR_WIDTH];

    // Non-blocking read of the old word gives read-first behaviour on a write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdat;
        end
        rdat <= mem[addr];
    end

endmodule

// File: rtl/unified_mem_ctrl.sv
// Arbitrates CPU instruction/data requests onto one single-port RAM with wait states.
// Ack arrives 1+WAIT_CYCLES cycles after accept; mem_stall holds the pipeline until then.
module unified_mem_ctrl
    import unified_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0,
    parameter     INIT_FILE   = ""
) (
    input  logic               clk,
    input  logic               cpu_rst_n,
    unified_mem_ctrl_if.slave  bus
);

    localparam bit                  HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(HAS_WAIT ? WAIT_CYCLES - 1 : 0);

    state_t                  state, state_nxt;
    port_t                   port_q, port_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic                    ram_we;
    logic [WORD_W-1:0]       ram_rdat;
    logic [WORD_W-1:0]       inst_hold, mem_hold;
    logic                    data_req;
    logic [ADDR_WIDTH-1:0]   inst_idx, mem_idx;
    logic                    resp_inst, resp_data;

    assign data_req = bus.mem_ren | bus.mem_wen;
    assign inst_idx = bus.inst_addr[ADDR_WIDTH+1:2];
    assign mem_idx  = bus.mem_addr[ADDR_WIDTH+1:2];

    // Byte offset and high address bits are deliberately ignored (address aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.inst_addr[WORD_W-1:ADDR_WIDTH+2], bus.inst_addr[1:0],
                                bus.mem_addr[WORD_W-1:ADDR_WIDTH+2],  bus.mem_addr[1:0]};

    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state  <= ST_IDLE;
            port_q <= PORT_INST;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            port_q <= port_nxt;
            addr_q <= addr_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        port_nxt  = port_q;
        addr_nxt  = addr_q;
        cnt_nxt   = cnt_q;
        ram_addr  = addr_q;
        ram_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Data port wins; the instruction request stays pending and stalls.
                ram_addr = data_req ? mem_idx : inst_idx;
                if (data_req || bus.inst_ren) begin
                    port_nxt  = data_req ? PORT_DATA : PORT_INST;
                    addr_nxt  = data_req ? mem_idx : inst_idx;
                    ram_we    = cpu_rst_n & data_req & bus.mem_wen;
                    cnt_nxt   = WAIT_LOAD;
                    state_nxt = HAS_WAIT ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    mem_sp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdat (bus.mem_dout),
        .rdat (ram_rdat)
    );

    assign resp_inst = (state == ST_RESP) && (port_q == PORT_INST);
    assign resp_data = (state == ST_RESP) && (port_q == PORT_DATA);

    // RAM output is live during RESP; the hold registers keep it afterwards.
    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            inst_hold <= '0;
            mem_hold  <= '0;
        end else begin
            if (resp_inst) inst_hold <= ram_rdat;
            if (resp_data) mem_hold  <= ram_rdat;
        end
    end

    assign bus.inst_ack  = resp_inst;
    assign bus.mem_ack   = resp_data;
    assign bus.inst_data = resp_inst ? ram_rdat : inst_hold;
    assign bus.mem_din   = resp_data ? ram_rdat : mem_hold;
    assign bus.mem_stall = cpu_rst_n & ((bus.inst_ren & ~bus.inst_ack) |
                                        (data_req & ~bus.mem_ack));

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed bench for unified_mem_ctrl: one instance with no wait states, one with three.
// A select signal routes the shared stimulus to one instance at a time.
module tb_unified_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        t_inst_ren;
    logic [31:0] t_inst_addr;
    logic        t_mem_ren;
    logic        t_mem_wen;
    logic [31:0] t_mem_addr;
    logic [31:0] t_mem_dout;

    int n_chk  = 0;
    int n_fail = 0;

    unified_mem_ctrl_if i0 ();
    unified_mem_ctrl_if i3 ();

    assign i0.inst_ren  = ~sel & t_inst_ren;
    assign i0.mem_ren   = ~sel & t_mem_ren;
    assign i0.mem_wen   = ~sel & t_mem_wen;
    assign i0.inst_addr = t_inst_addr;
    assign i0.mem_addr  = t_mem_addr;
    assign i0.mem_dout  = t_mem_dout;
    assign i3.inst_ren  = sel & t_inst_ren;
    assign i3.mem_ren   = sel & t_mem_ren;
    assign i3.mem_wen   = sel & t_mem_wen;
    assign i3.inst_addr = t_inst_addr;
    assign i3.mem_addr  = t_mem_addr;
    assign i3.mem_dout  = t_mem_dout;

    wire        inst_ack  = sel ? i3.inst_ack  : i0.inst_ack;
    wire        mem_ack   = sel ? i3.mem_ack   : i0.mem_ack;
    wire [31:0] inst_data = sel ? i3.inst_data : i0.inst_data;
    wire [31:0] mem_din   = sel ? i3.mem_din   : i0.mem_din;
    wire        mem_stall = sel ? i3.mem_stall : i0.mem_stall;

    unified_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut0 (
        .clk       (clk),
        .cpu_rst_n (rst_n),
        .bus       (i0)
    );

    unified_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .INIT_FILE("")) u_dut3 (
        .clk       (clk),
        .cpu_rst_n (rst_n),
        .bus       (i3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req();
        t_inst_ren = 1'b0;
        t_mem_ren  = 1'b0;
        t_mem_wen  = 1'b0;
    endtask

    // Issue one request at the start of a cycle and check stall/ack timing and data.
    task automatic xfer(input string tag, input bit data_port, input bit wen, input bit ren,
                        input logic [31:0] addr, input logic [31:0] wdat, input int lat,
                        input bit chk_dat, input logic [31:0] exp);
        logic a;
        if (data_port) begin
            t_mem_wen  = wen;
            t_mem_ren  = ren;
            t_mem_addr = addr;
            t_mem_dout = wdat;
        end else begin
            t_inst_ren  = 1'b1;
            t_inst_addr = addr;
        end
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            a = data_port ? mem_ack : inst_ack;
            if (c < lat) begin
                check({tag, "_noack"}, {31'd0, a}, 32'd0);
                check({tag, "_stall"}, {31'd0, mem_stall}, 32'd1);
            end else begin
                check({tag, "_ack"}, {31'd0, a}, 32'd1);
                check({tag, "_stall_rel"}, {31'd0, mem_stall}, 32'd0);
                if (chk_dat) check({tag, "_dat"}, data_port ? mem_din : inst_data, exp);
            end
            next_cycle();
        end
        idle_req();
        @(negedge clk);
        check({tag, "_single"}, {30'd0, inst_ack, mem_ack}, 32'd0);
        next_cycle();
    endtask

    initial begin
        bit seen;
        sel = 1'b0;
        rst_n = 1'b0;
        idle_req();
        t_inst_addr = '0;
        t_mem_addr  = '0;
        t_mem_dout  = '0;
        t_mem_ren   = 1'b1;
        @(negedge clk);
        check("rst_acks", {30'd0, i0.inst_ack, i0.mem_ack}, 32'd0);
        check("rst_acks3", {30'd0, i3.inst_ack, i3.mem_ack}, 32'd0);
        check("rst_inst_data", i0.inst_data, 32'd0);
        check("rst_mem_din", i0.mem_din, 32'd0);
        check("rst_stall", {31'd0, i0.mem_stall}, 32'd0);
        next_cycle();
        idle_req();
        rst_n = 1'b1;
        next_cycle();

        // No wait states
        xfer("w0_wr10", 1, 1, 0, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0);
        xfer("w0_rd10", 1, 0, 1, 32'h10, 32'h0, 1, 1, 32'hDEADBEEF);
        xfer("w0_wr14", 1, 1, 0, 32'h14, 32'hCAFEF00D, 1, 0, 32'h0);

        // Simultaneous requests: data first, instruction two cycles later
        t_inst_ren = 1'b1; t_inst_addr = 32'h10;
        t_mem_ren  = 1'b1; t_mem_addr  = 32'h14;
        @(negedge clk);
        check("sim_c0_stall", {31'd0, mem_stall}, 32'd1);
        check("sim_c0_acks", {30'd0, inst_ack, mem_ack}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("sim_c1_acks", {30'd0, inst_ack, mem_ack}, 32'd1);
        check("sim_c1_dat", mem_din, 32'hCAFEF00D);
        check("sim_c1_stall", {31'd0, mem_stall}, 32'd1);
        next_cycle();
        t_mem_ren = 1'b0;
        @(negedge clk);
        check("sim_c2_acks", {30'd0, inst_ack, mem_ack}, 32'd0);
        check("sim_c2_stall", {31'd0, mem_stall}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("sim_c3_acks", {30'd0, inst_ack, mem_ack}, 32'd2);
        check("sim_c3_dat", inst_data, 32'hDEADBEEF);
        check("sim_c3_stall", {31'd0, mem_stall}, 32'd0);
        check("sim_c3_hold", mem_din, 32'hCAFEF00D);
        next_cycle();
        idle_req();
        next_cycle();

        // Address aliasing and ignored byte offset
        xfer("alias_wr1000", 1, 1, 0, 32'h1000, 32'h12345678, 1, 0, 32'h0);
        xfer("alias_rd0000", 1, 0, 1, 32'h0000, 32'h0, 1, 1, 32'h12345678);
        xfer("alias_rd0013", 1, 0, 1, 32'h0013, 32'h0, 1, 1, 32'hDEADBEEF);
        xfer("alias_if1002", 0, 0, 0, 32'h1002, 32'h0, 1, 1, 32'h12345678);

        // Simultaneous read and write behaves as read-first write
        xfer("rw_wr20", 1, 1, 0, 32'h20, 32'h1, 1, 0, 32'h0);
        xfer("rw_both", 1, 1, 1, 32'h20, 32'h2, 1, 1, 32'h1);
        xfer("rw_rd20", 1, 0, 1, 32'h20, 32'h0, 1, 1, 32'h2);

        // Three wait states
        sel = 1'b1;
        next_cycle();
        xfer("w3_wr10", 1, 1, 0, 32'h10, 32'hDEADBEEF, 4, 0, 32'h0);
        xfer("w3_wr30", 1, 1, 0, 32'h30, 32'h55AA55AA, 4, 0, 32'h0);
        xfer("w3_rd30", 1, 0, 1, 32'h30, 32'h0, 4, 1, 32'h55AA55AA);
        xfer("w3_if10", 0, 0, 0, 32'h10, 32'h0, 4, 1, 32'hDEADBEEF);

        // Reset in the middle of a waited read
        t_mem_ren = 1'b1; t_mem_addr = 32'h30;
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        idle_req();
        @(negedge clk);
        check("mid_rst_acks", {30'd0, inst_ack, mem_ack}, 32'd0);
        check("mid_rst_mem_din", mem_din, 32'd0);
        check("mid_rst_inst_data", inst_data, 32'd0);
        check("mid_rst_stall", {31'd0, mem_stall}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (inst_ack || mem_ack) seen = 1'b1;
        end
        check("post_rst_no_ack", {31'd0, seen}, 32'd0);
        next_cycle();
        xfer("w3_reissue30", 1, 0, 1, 32'h30, 32'h0, 4, 1, 32'h55AA55AA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
